// File: rtl/usb_readout_controller_pkg.sv
// Shared definitions for the FT245 readout controller: FSM encoding and command bytes.
package usb_readout_controller_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CMD_RD     = 3'd1,
        CMD_DECODE = 3'd2,
        READOUT    = 3'd3,
        DRAIN      = 3'd4
    } state_t;

    localparam logic [7:0] CMD_ACQUIRE = 8'h41;
    localparam logic [7:0] CMD_READ    = 8'h52;

endpackage

// File: rtl/usb_readout_controller_sync_fifo.sv
// Small synchronous FIFO with show-ahead head output; holds RAM bytes waiting for FT245 write slots.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/usb_readout_controller.sv
// FT245 command/readout controller: reads one command byte, pulses acquisition or streams
// nr_lines RAM bytes to the host through a credit-limited skid FIFO.
module usb_readout_controller
    import usb_readout_controller_pkg::*;
#(
    parameter int log_nr_lines = 10,
    parameter int nr_lines     = 1024,
    parameter int RD_LATENCY   = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    rxf_n,
    input  logic                    txe_n,
    input  logic [7:0]              usb_din,
    input  logic [7:0]              send_byte,
    output logic                    rd_n,
    output logic                    wr_n,
    output logic [7:0]              usb_dout,
    output logic                    usb_oe,
    output logic [log_nr_lines-1:0] ram_rd_address,
    output logic                    acquire_signal,
    output logic                    busy,
    output state_t                  fsm_state
);

    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int CW  = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
    localparam logic [log_nr_lines-1:0] LAST_ADDR = log_nr_lines'(nr_lines - 1);

    state_t                  state;
    state_t                  state_next;
    logic                    rxf_meta, rxf_s;
    logic                    txe_meta, txe_s;
    logic                    rd_cnt;
    logic [7:0]              cmd;
    logic [log_nr_lines-1:0] addr;
    logic [RD_LATENCY-1:0]   vpipe;
    logic [CW-1:0]           in_flight;
    logic                    credit_ok;
    logic                    issue;
    logic                    clear_counters;
    logic                    write_start;
    logic [7:0]              fifo_head;
    logic [FCW-1:0]          fifo_count;
    logic                    fifo_empty;
    logic                    fifo_full;

    // Handshake: an address counts as issued in a READOUT cycle where credit_ok is high;
    // its byte is pushed RD_LATENCY cycles later, so in_flight + fifo_count bounds occupancy.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            in_flight = in_flight + CW'(vpipe[i]);
        end
    end

    assign credit_ok      = (in_flight + CW'(fifo_count)) < CW'(FIFO_DEPTH);
    assign issue          = (state == READOUT) && credit_ok;
    assign clear_counters = (state == CMD_DECODE) && (cmd == CMD_READ);
    assign write_start    = !fifo_empty && !txe_s && wr_n;

    assign rd_n           = (state != CMD_RD);
    assign usb_oe         = (state == READOUT) || (state == DRAIN);
    assign acquire_signal = (state == CMD_DECODE) && (cmd == CMD_ACQUIRE);
    assign busy           = (state != IDLE);
    assign ram_rd_address = addr;
    assign fsm_state      = state;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (!rxf_s) state_next = CMD_RD;
            CMD_RD:     if (rd_cnt) state_next = CMD_DECODE;
            CMD_DECODE: state_next = (cmd == CMD_READ) ? READOUT : IDLE;
            READOUT:    if (issue && (addr == LAST_ADDR)) state_next = DRAIN;
            // wr_n must be back high so the final strobe completes while the bus is still owned
            DRAIN:      if ((in_flight == '0) && fifo_empty && wr_n) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rxf_meta <= 1'b1;
            rxf_s    <= 1'b1;
            txe_meta <= 1'b1;
            txe_s    <= 1'b1;
            state    <= IDLE;
            rd_cnt   <= 1'b0;
            cmd      <= 8'h00;
            addr     <= '0;
            vpipe    <= '0;
            wr_n     <= 1'b1;
            usb_dout <= 8'h00;
        end else begin
            rxf_meta <= rxf_n;
            rxf_s    <= rxf_meta;
            txe_meta <= txe_n;
            txe_s    <= txe_meta;
            state    <= state_next;
            rd_cnt   <= (state == CMD_RD) ? !rd_cnt : 1'b0;
            if ((state == CMD_RD) && rd_cnt) begin
                cmd <= usb_din;
            end
            if (clear_counters) begin
                addr  <= '0;
                vpipe <= '0;
            end else begin
                if (issue && (addr != LAST_ADDR)) begin
                    addr <= addr + log_nr_lines'(1);
                end
                vpipe[0] <= issue;
                for (int i = 1; i < RD_LATENCY; i++) begin
                    vpipe[i] <= vpipe[i-1];
                end
            end
            wr_n <= !write_start;
            if (write_start) begin
                usb_dout <= fifo_head;
            end
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLOCK_50),
        .reset (reset),
        .push  (vpipe[RD_LATENCY-1]),
        .din   (send_byte),
        .pop   (write_start),
        .dout  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule
